gpr_file_fwd: RTL and testbench

Parametrised successor to the ID-stage general-purpose register file. Provides NRD read ports with priority bypass from NFWD pipeline stages plus write-through from the writeback port. Adds async clear of all registers and a busy-bit scoreboard for long-latency producers (mul/div). Raises per-port hazard flags and a combined stall request when an enabled read cannot be satisfied, either because of a load-use case or because its register is busy.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/fwd_select.sv | 47 ++++
 rtl/gpr_file_fwd.sv | 94 +++++++++
 tb/tb_gpr_file_fwd.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the forwarding register file.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 2;
    localparam int NFWD_DEF   = 3;

    // Architectural zero register index.
    localparam int REG_ZERO   = 0;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_w(input int nregs);
        return (nregs <= 1) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-read-port source select: zero reg, youngest forward, write-through, array.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; reports hazard when the selected source is not ready/busy.
module fwd_select
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = 5,
    parameter int NFWD   = NFWD_DEF
) (
    input  logic [AW-1:0]          raddr,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W-1:0]      arr_data,
    input  logic                   arr_busy,
    output logic [DATA_W-1:0]      rdata,
    output logic                   hazard
);

    // Lowest-priority source first, each later assignment overrides: array,
    // then write-through, then forwards scanned oldest to youngest so the
    // youngest match wins, then the zero register on top of everything.
    always_comb begin
        rdata  = arr_data;
        hazard = arr_busy;
        if (we && (waddr == raddr)) begin
            rdata  = wdata;
            hazard = 1'b0;
        end
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == raddr)) begin
                rdata  = fwd_wdata[i*DATA_W +: DATA_W];
                hazard = ~fwd_ready[i];
            end
        end
        if (raddr == AW'(REG_ZERO)) begin
            rdata  = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/gpr_file_fwd.sv
// Register file with per-port forwarding, write-through and busy scoreboard.
// Latency: reads combinational (0 cycles); writes and busy updates on clk rise.
// Backpressure: raises stall_req when an enabled read port has a hazard.
module gpr_file_fwd
    import regfile_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = NRD_DEF,
    parameter  int NFWD   = NFWD_DEF,
    localparam int AW     = addr_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*AW-1:0]      raddr,
    output logic [NRD*DATA_W-1:0]  rdata,
    output logic [NRD-1:0]         rd_hazard,
    output logic                   stall_req,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_set_addr,
    input  logic                   sb_clr,
    input  logic [AW-1:0]          sb_clr_addr,
    input  logic                   flush
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    // Architectural state: async clear, writes to the zero register dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    // Busy scoreboard: flush beats everything; set is applied after clear so
    // a same-address set/clear pair leaves the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (sb_clr) begin
                busy[sb_clr_addr] <= 1'b0;
            end
            if (sb_set && (sb_set_addr != AW'(REG_ZERO))) begin
                busy[sb_set_addr] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] port_addr;
        assign port_addr = raddr[r*AW +: AW];

        fwd_select #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NFWD   (NFWD)
        ) u_sel (
            .raddr     (port_addr),
            .fwd_we    (fwd_we),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .fwd_ready (fwd_ready),
            .we        (we),
            .waddr     (waddr),
            .wdata     (wdata),
            .arr_data  (regs[port_addr]),
            .arr_busy  (busy[port_addr]),
            .rdata     (rdata[r*DATA_W +: DATA_W]),
            .hazard    (rd_hazard[r])
        );
    end

    // A hazard on an unused port never stalls the pipeline.
    always_comb begin
        stall_req = |(rd_en & rd_hazard);
    end

endmodule

// File: tb/tb_gpr_file_fwd.sv
// Directed bench for gpr_file_fwd with hand-computed expected values.
// Latency: reads checked 1ns after inputs settle; state checked after clk rise.
// Backpressure: stall_req checked against rd_en/hazard combinations.
module tb_gpr_file_fwd;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NFWD = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*DW-1:0]    rdata;
    logic [NRD-1:0]       rd_hazard;
    logic                 stall_req;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_waddr;
    logic [NFWD*DW-1:0]   fwd_wdata;
    logic [NFWD-1:0]      fwd_ready;
    logic                 sb_set;
    logic [AW-1:0]        sb_set_addr;
    logic                 sb_clr;
    logic [AW-1:0]        sb_clr_addr;
    logic                 flush;

    int checks;
    int errors;

    gpr_file_fwd dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .raddr       (raddr),
        .rdata       (rdata),
        .rd_hazard   (rd_hazard),
        .stall_req   (stall_req),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_ready   (fwd_ready),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_clr      (sb_clr),
        .sb_clr_addr (sb_clr_addr),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rd_en       = '0;
        raddr       = '0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_ready   = '0;
        sb_set      = 1'b0;
        sb_set_addr = '0;
        sb_clr      = 1'b0;
        sb_clr_addr = '0;
        flush       = 1'b0;
    endtask

    // Advance past the next rising edge; inputs may be changed afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic set_fwd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
        fwd_we[i]             = 1'b1;
        fwd_waddr[i*AW +: AW] = a;
        fwd_wdata[i*DW +: DW] = d;
        fwd_ready[i]          = rdy;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        rd_en = 2'b11;
        set_rd(0, 5'd3);
        set_rd(1, 5'd17);
        #12;
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        checks++;
        if (rd_hazard !== 2'b00 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard: got hz=%b stall=%b expected 00/0", rd_hazard, stall_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int a = 1; a < 32; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(32 - a));
            #1;
            checks++;
            if (rdata !== '0 || stall_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_scan r%0d: got rdata=%h stall=%b expected 0/0", a, rdata, stall_req);
            end
        end
    endtask

    task automatic test_write_through();
        idle_inputs();
        rd_en = 2'b01;
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        set_rd(0, 5'd5);
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'hDEADBEEF || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_through: got %h hz=%b expected deadbeef/0", rdata[0 +: DW], rd_hazard[0]);
        end
        step();
        we    = 1'b0;
        wdata = '0;
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL array_read: got %h expected deadbeef", rdata[0 +: DW]);
        end
        // Zero register always reads zero even with a write-through pending.
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'h55555555;
        set_rd(1, 5'd0);
        #1;
        checks++;
        if (rdata[DW +: DW] !== '0) begin
            errors++;
            $display("FAIL r0_write_through: got %h expected 0", rdata[DW +: DW]);
        end
        step();
    endtask

    task automatic test_forward();
        idle_inputs();
        rd_en = 2'b10;
        set_rd(1, 5'd7);
        set_fwd(0, 5'd7, 32'h11, 1'b1);
        set_fwd(1, 5'd7, 32'h22, 1'b1);
        #1;
        checks++;
        if (rdata[DW +: DW] !== 32'h11 || rd_hazard[1] !== 1'b0) begin
            errors++;
            $display("FAIL fwd_youngest: got %h hz=%b expected 11/0", rdata[DW +: DW], rd_hazard[1]);
        end
        fwd_ready[0] = 1'b0;
        #1;
        checks++;
        if (rd_hazard[1] !== 1'b1 || stall_req !== 1'b1 || rdata[DW +: DW] !== 32'h11) begin
            errors++;
            $display("FAIL fwd_load_use: got hz=%b stall=%b d=%h expected 1/1/11", rd_hazard[1], stall_req, rdata[DW +: DW]);
        end
        rd_en = 2'b00;
        #1;
        checks++;
        if (stall_req !== 1'b0 || rd_hazard[1] !== 1'b1) begin
            errors++;
            $display("FAIL fwd_rd_en_gate: got stall=%b hz=%b expected 0/1", stall_req, rd_hazard[1]);
        end
        // Both ports on the same address see the same result.
        rd_en = 2'b11;
        set_rd(0, 5'd7);
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'h11 || rd_hazard !== 2'b11 || stall_req !== 1'b1) begin
            errors++;
            $display("FAIL fwd_same_addr: got d0=%h hz=%b stall=%b expected 11/11/1", rdata[0 +: DW], rd_hazard, stall_req);
        end
        // Oldest source alone, and forwarding beats write-through.
        idle_inputs();
        rd_en = 2'b01;
        set_rd(0, 5'd5);
        set_fwd(2, 5'd5, 32'h33, 1'b1);
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'h44;
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'h33 || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL fwd_over_wb: got %h hz=%b expected 33/0", rdata[0 +: DW], rd_hazard[0]);
        end
        we = 1'b0;
        #1;
        step();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rd_en       = 2'b01;
        set_rd(0, 5'd9);
        sb_set      = 1'b1;
        sb_set_addr = 5'd9;
        #1;
        checks++;
        if (rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_not_yet_visible: got hz=%b expected 0", rd_hazard[0]);
        end
        step();
        sb_set = 1'b0;
        #1;
        checks++;
        if (rd_hazard[0] !== 1'b1 || stall_req !== 1'b1) begin
            errors++;
            $display("FAIL sb_busy: got hz=%b stall=%b expected 1/1", rd_hazard[0], stall_req);
        end
        sb_clr      = 1'b1;
        sb_clr_addr = 5'd9;
        we          = 1'b1;
        waddr       = 5'd9;
        wdata       = 32'h1234;
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'h1234 || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_wb_through: got %h hz=%b expected 1234/0", rdata[0 +: DW], rd_hazard[0]);
        end
        step();
        sb_clr = 1'b0;
        we     = 1'b0;
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'h1234 || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: got %h hz=%b expected 1234/0", rdata[0 +: DW], rd_hazard[0]);
        end
        sb_set      = 1'b1;
        sb_set_addr = 5'd9;
        sb_clr      = 1'b1;
        sb_clr_addr = 5'd9;
        step();
        sb_set = 1'b0;
        sb_clr = 1'b0;
        #1;
        checks++;
        if (rd_hazard[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: got hz=%b expected 1", rd_hazard[0]);
        end
        // A ready forward on a busy register bypasses the scoreboard.
        set_fwd(1, 5'd9, 32'h77, 1'b1);
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'h77 || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_fwd_bypass: got %h hz=%b expected 77/0", rdata[0 +: DW], rd_hazard[0]);
        end
        fwd_we      = '0;
        sb_clr      = 1'b1;
        sb_clr_addr = 5'd9;
        step();
        sb_clr = 1'b0;
    endtask

    task automatic test_flush();
        idle_inputs();
        rd_en = 2'b11;
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        sb_set      = 1'b1;
        sb_set_addr = 5'd3;
        step();
        sb_set_addr = 5'd4;
        step();
        sb_set = 1'b0;
        #1;
        checks++;
        if (rd_hazard !== 2'b11) begin
            errors++;
            $display("FAIL flush_pre_busy: got hz=%b expected 11", rd_hazard);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (rd_hazard !== 2'b00 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears: got hz=%b stall=%b expected 00/0", rd_hazard, stall_req);
        end
        set_rd(0, 5'd6);
        flush       = 1'b1;
        sb_set      = 1'b1;
        sb_set_addr = 5'd6;
        step();
        flush  = 1'b0;
        sb_set = 1'b0;
        #1;
        checks++;
        if (rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_set: got hz=%b expected 0", rd_hazard[0]);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        rd_en       = 2'b11;
        set_rd(0, 5'd10);
        set_rd(1, 5'd5);
        we          = 1'b1;
        waddr       = 5'd10;
        wdata       = 32'hA5A5A5A5;
        sb_set      = 1'b1;
        sb_set_addr = 5'd10;
        step();
        idle_inputs();
        rd_en = 2'b11;
        set_rd(0, 5'd10);
        set_rd(1, 5'd5);
        #1;
        checks++;
        if (rdata[0 +: DW] !== 32'hA5A5A5A5 || rd_hazard[0] !== 1'b1 || rdata[DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pre_reset_state: got d0=%h hz=%b d1=%h expected a5a5a5a5/1/deadbeef", rdata[0 +: DW], rd_hazard[0], rdata[DW +: DW]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata !== '0 || rd_hazard !== 2'b00 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got d=%h hz=%b stall=%b expected 0/00/0", rdata, rd_hazard, stall_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        set_rd(0, 5'd0);
        #1;
        checks++;
        if (rdata[0 +: DW] !== '0 || rd_hazard[0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_write_dropped: got %h hz=%b expected 0/0", rdata[0 +: DW], rd_hazard[0]);
        end
        checks++;
        if (rdata[DW +: DW] !== '0) begin
            errors++;
            $display("FAIL reset_lost_r5: got %h expected 0", rdata[DW +: DW]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_write_through();
        test_forward();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
